decode_scheduler: RTL and testbench
===================================

# decode_scheduler

Round-robin scheduler that shares one multi-cycle decode unit among `NUM_REQ` requesters. It sits between the requesters and the decode unit. It accepts one request at a time over a valid/ready handshake and issues a one-cycle start strobe to the decode unit. It then waits for completion, or for a timeout, and returns the result tagged with the requester id. Sequencing uses a 2-bit state register with a separate next-state decode.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `DATA_WIDTH`, default 8: width of request and result payload.
- `TIMEOUT`, default 15: maximum cycles spent waiting for `dec_done`, range 1..255.
- `ID_W`, default `$clog2(NUM_REQ)`: derived width of the requester id.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low. Asserts immediately, releases synchronously to `clk`.
- `req_valid`  in  `NUM_REQ`: per-requester request valid.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`: packed payloads; requester i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`  out  `NUM_REQ`: per-requester accept, at most one-hot.
- `dec_start`  out  1: one-cycle start strobe to the decode unit.
- `dec_data`  out  `DATA_WIDTH`: latched payload presented to the decode unit.
- `dec_done`  in  1: decode complete; sampled only in state WAIT.
- `dec_result`  in  `DATA_WIDTH`: decode result, valid with `dec_done`.
- `rsp_valid`  out  1: response valid.
- `rsp_id`  out  `ID_W`: requester the response belongs to.
- `rsp_data`  out  `DATA_WIDTH`: response payload.
- `rsp_err`  out  1: response is a timeout, not a decode result.
- `rsp_ready`  in  1: consumer accepts the response.

## Operation
State encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.

IDLE:
- The winner is the first requester with `req_valid` set, scanning upward from `last_grant+1` modulo `NUM_REQ`.
- `req_ready[winner]` is driven combinationally in this same cycle. All other `req_ready` bits are 0.
- If any request is valid: latch `cur_id=winner` and `cur_data=req_data[winner]`, then go to ISSUE.
- If none is valid: stay in IDLE, with all `req_ready` bits 0.

ISSUE:
- `dec_start=1` for exactly this cycle.
- Clear the timer to 0.
- Go to WAIT unconditionally. `dec_done` is ignored in this state.

WAIT:
- If `dec_done`: latch `rsp_data=dec_result` and `rsp_err=0`, go to RESP.
- Otherwise, if the timer equals `TIMEOUT-1`: latch `rsp_data=0` and `rsp_err=1`, go to RESP.
- Otherwise: increment the timer and stay in WAIT.
- If `dec_done` arrives in the timeout cycle, `dec_done` wins.

RESP:
- `rsp_valid=1`, `rsp_id=cur_id`.
- Hold every response field stable until `rsp_ready`.
- On `rsp_valid & rsp_ready`: set `last_grant=cur_id` and go to IDLE.

General rules:
- `dec_data` is driven by `cur_data` at all times.
- `req_ready` is all zero in every state except IDLE.
- `last_grant` updates only on response handshake. A timed-out requester therefore still loses priority.
- The timer width is `$clog2(TIMEOUT+1)`. It never wraps, because it is cleared in ISSUE and stops at `TIMEOUT-1`.

Reset values, forced on `rst`=0 regardless of the clock:
- state=IDLE.
- `last_grant=NUM_REQ-1`, so requester 0 wins first.
- timer=0, `cur_id=0`, `cur_data=0`.
- `rsp_data=0`, `rsp_err=0`.
- All outputs 0.

If reset asserts mid-transaction, the in-flight request is dropped and no response is produced. The decode unit must be reset with the same `rst`.

## Timing
- Request accepted in cycle T (IDLE) → `dec_start` in T+1 → WAIT from T+2.
- If `dec_done` is seen in cycle T+2+k, `rsp_valid` asserts in T+3+k. Minimum accept-to-response latency is 3 cycles.
- Timeout case: `rsp_valid` asserts in T+2+`TIMEOUT`.
- Response handshake in cycle R → IDLE in R+1. The next accept can occur in R+1.
- Minimum request-to-request spacing is 4 cycles.
- `req_ready` depends combinationally on `req_valid`. `rsp_valid` depends only on the registered state; there is no combinational path from `rsp_ready` to `rsp_valid`.

## Test plan
- Reset, then `req_valid`=4'b1111 with `dec_done` always returned 1 cycle after `dec_start` and `rsp_ready`=1 → grant order 0,1,2,3,0, with `rsp_id` following that order.
- Single request from id 2, data 8'hA5, `dec_result`=8'h5A on the first WAIT cycle → `req_ready`=4'b0100 at T, `dec_start` at T+1, `rsp_valid`/`rsp_id`=2/`rsp_data`=8'h5A/`rsp_err`=0 at T+3.
- `dec_done` never asserted, `TIMEOUT`=15 → `rsp_valid` at T+17 with `rsp_err`=1 and `rsp_data`=0; the next grant skips past that id.
- `rsp_ready` held low for 5 cycles in RESP while new requests are pending → `rsp_*` stable throughout, `req_ready`=0 throughout, accept in the cycle after the handshake.
- `dec_done` asserted in the ISSUE cycle and again exactly at the timeout cycle → the ISSUE-cycle pulse is ignored; the timeout-cycle pulse yields `rsp_err`=0 with `dec_result` data.
- `rst` driven low while in WAIT, asynchronous to `clk` → all outputs 0 immediately; after release, requester 0 wins first.

Source files
------------

// File: rtl/decode_scheduler.sv
// Round-robin scheduler sharing one multi-cycle decode unit among NUM_REQ requesters.
// Issues a one-cycle start strobe, waits for done or timeout, returns a tagged response.
module decode_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          dec_start,
  output logic [DATA_WIDTH-1:0]         dec_data,
  input  logic                          dec_done,
  input  logic [DATA_WIDTH-1:0]         dec_result,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  input  logic                          rsp_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMAX     = TW'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [ID_W-1:0]       cur_id_q, cur_id_d;
  logic [DATA_WIDTH-1:0] cur_data_q, cur_data_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic [DATA_WIDTH-1:0] req_arr [NUM_REQ];
  logic                  found;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       scan_id;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan upward from last_grant+1; the first valid requester found wins.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    scan_id = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      scan_id = ID_W'((32'(last_grant_q) + off) % NUM_REQ);
      if (!found && req_valid[scan_id]) begin
        found  = 1'b1;
        winner = scan_id;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    cur_data_d   = cur_data_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    timer_d      = timer_q;
    req_ready    = '0;
    dec_start    = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        if (found && rst) begin
          req_ready[winner] = 1'b1;
          cur_id_d          = winner;
          cur_data_d        = req_arr[winner];
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        dec_start = 1'b1;
        timer_d   = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (dec_done) begin
          rsp_data_d = dec_result;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (timer_q == TMAX) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          last_grant_d = cur_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      cur_id_q     <= '0;
      cur_data_q   <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      cur_data_q   <= cur_data_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      timer_q      <= timer_d;
    end
  end

  assign dec_data  = cur_data_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = cur_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_decode_scheduler.sv
// Directed bench for decode_scheduler: expected responses queued at accept, checked at handshake.
module tb_decode_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 15;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             dec_start;
  logic [DW-1:0]    dec_data;
  logic             dec_done;
  logic [DW-1:0]    dec_result;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic             rsp_ready;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  decode_scheduler #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dec_start (dec_start),
    .dec_data  (dec_data),
    .dec_done  (dec_done),
    .dec_result(dec_result),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // done_k < 0 means dec_done never arrives (timeout expected).
  task automatic run_txn(input logic [NR-1:0] mask, input int exp_id, input int done_k,
                         input logic [DW-1:0] result, input int hold, input bit issue_pulse);
    exp_t          e;
    exp_t          got;
    logic [DW-1:0] exp_payload;
    logic [IW-1:0] sid;
    logic [DW-1:0] sdata;
    logic          serr;
    req_valid = mask;
    #1;
    chk("idle_req_ready", 64'(req_ready), 64'(NR'(1) << exp_id));
    exp_payload = req_data[exp_id*DW +: DW];
    e.id   = IW'(exp_id);
    e.data = (done_k >= 0) ? result : '0;
    e.err  = (done_k < 0);
    sb.push_back(e);
    step();
    if (issue_pulse) begin
      dec_done   = 1'b1;
      dec_result = 8'hBD;
    end
    #1;
    chk("issue_dec_start", 64'(dec_start), 64'(1));
    chk("issue_dec_data", 64'(dec_data), 64'(exp_payload));
    chk("issue_req_ready", 64'(req_ready), 64'(0));
    step();
    dec_done   = 1'b0;
    dec_result = 8'hEE;
    for (int k = 0; k < TO; k++) begin
      chk("wait_quiet", 64'({dec_start, rsp_valid}), 64'(0));
      if (k == done_k) begin
        dec_done   = 1'b1;
        dec_result = result;
      end
      step();
      dec_done   = 1'b0;
      dec_result = 8'hEE;
      if (k == done_k) break;
    end
    chk("resp_valid", 64'(rsp_valid), 64'(1));
    sid   = rsp_id;
    sdata = rsp_data;
    serr  = rsp_err;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      #1;
      chk("resp_hold_stable", 64'({rsp_valid, rsp_id, rsp_data, rsp_err}),
          64'({1'b1, sid, sdata, serr}));
      chk("resp_hold_req_ready", 64'(req_ready), 64'(0));
      step();
    end
    rsp_ready = 1'b1;
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_underflow observed=empty expected=entry");
    end else begin
      got = sb.pop_front();
      chk("rsp_valid_hs", 64'(rsp_valid), 64'(1));
      chk("rsp_id", 64'(rsp_id), 64'(got.id));
      chk("rsp_data", 64'(rsp_data), 64'(got.data));
      chk("rsp_err", 64'(rsp_err), 64'(got.err));
    end
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = '1;
    req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    dec_done   = 1'b0;
    dec_result = 8'hEE;
    rsp_ready  = 1'b0;
    #3;
    chk("reset_outputs", 64'({req_ready, dec_start, dec_data, rsp_valid, rsp_id, rsp_data, rsp_err}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Full contention: strict rotation starting at requester 0.
    run_txn(4'b1111, 0, 0, 8'h80, 0, 1'b0);
    run_txn(4'b1111, 1, 0, 8'h81, 0, 1'b0);
    run_txn(4'b1111, 2, 0, 8'h82, 0, 1'b0);
    run_txn(4'b1111, 3, 0, 8'h83, 0, 1'b0);
    run_txn(4'b1111, 0, 0, 8'h84, 0, 1'b0);

    // Single requester 2 with distinctive payload.
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    run_txn(4'b0100, 2, 0, 8'h5A, 0, 1'b0);

    // Timeout on requester 3; next grant must skip to 0.
    run_txn(4'b1111, 3, -1, 8'h00, 0, 1'b0);

    // Back-pressure for 5 cycles with requests pending.
    run_txn(4'b1111, 0, 0, 8'hC3, 5, 1'b0);

    // ISSUE-cycle pulse ignored; done in timeout cycle wins.
    run_txn(4'b1111, 1, TO - 1, 8'h3C, 0, 1'b1);

    // Asynchronous reset while waiting for the decode unit.
    req_valid = 4'b1111;
    #1;
    chk("pre_reset_grant", 64'(req_ready), 64'(4'b0100));
    step();
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({req_ready, dec_start, dec_data, rsp_valid, rsp_id, rsp_data, rsp_err}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_txn(4'b1111, 0, 1, 8'h77, 0, 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
